// File: rtl/regfile_2r1w_if.sv
// Register-file access bundle: two read addresses with their data, and one write port.
// Latency: none (pure signal bundle).
// Backpressure: none; every access completes in the cycle it is presented.
//
// Ports (signals):
//   Ra, Rb : read addresses (rs, rt)
//   Wr, We : write address and write enable
//   D      : write data
//   Qa, Qb : read data
// Modports:
//   master : datapath side, drives addresses/write data and samples read data
//   slave  : register file side
interface regfile_2r1w_if #(
  parameter int WIDTH = 32
);
  logic [4:0]       Ra;
  logic [4:0]       Rb;
  logic [4:0]       Wr;
  logic             We;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Qa;
  logic [WIDTH-1:0] Qb;

  modport master (
    output Ra, Rb, Wr, We, D,
    input  Qa, Qb
  );

  modport slave (
    input  Ra, Rb, Wr, We, D,
    output Qa, Qb
  );
endinterface

// File: rtl/regfile_2r1w.sv
// MIPS 32x32 register file: two combinational read ports, one synchronous write port; r0 reads as zero.
// Latency: reads 0 cycles; writes visible the cycle after the committing edge (same cycle with bypass).
// Backpressure: none; a write is accepted on every rising edge with We=1 outside reset.
//
// Ports:
//   Clk  : clock, writes commit on the rising edge
//   Clrn : asynchronous active-low reset, clears all registers
//   rf   : regfile_2r1w_if.slave (Ra, Rb, Wr, We, D in; Qa, Qb out)
// Optional build macro:
//   REGFILE_BYPASS_EN : forward D to a read port addressing the register being written
module regfile_2r1w #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
) (
  input  logic           Clk,
  input  logic           Clrn,
  regfile_2r1w_if.slave  rf
);

  // Entry 0 is not stored; reads of address 0 are forced to zero below.
  logic [WIDTH-1:0] regs_q [1:DEPTH-1];
  logic [WIDTH-1:0] regs_d [1:DEPTH-1];

  logic             wr_hit;
  logic [WIDTH-1:0] arr_qa;
  logic [WIDTH-1:0] arr_qb;

  assign wr_hit = rf.We && (rf.Wr != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) begin
      regs_d[rf.Wr] = rf.D;
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign arr_qa = (rf.Ra == 5'd0) ? '0 : regs_q[rf.Ra];
  assign arr_qb = (rf.Rb == 5'd0) ? '0 : regs_q[rf.Rb];

`ifdef REGFILE_BYPASS_EN
  // Forward the in-flight write; gated by Clrn so reset always reads zero.
  assign rf.Qa = (Clrn && wr_hit && (rf.Ra == rf.Wr)) ? rf.D : arr_qa;
  assign rf.Qb = (Clrn && wr_hit && (rf.Rb == rf.Wr)) ? rf.D : arr_qb;
`else
  assign rf.Qa = arr_qa;
  assign rf.Qb = arr_qb;
`endif

endmodule

// File: tb/tb_regfile_2r1w.sv
module tb_regfile_2r1w;

  logic Clk;
  logic Clrn;

  regfile_2r1w_if #(.WIDTH(32)) rf ();

  regfile_2r1w #(.DEPTH(32), .WIDTH(32)) dut (
    .Clk  (Clk),
    .Clrn (Clrn),
    .rf   (rf.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Reference model: plain array, index 0 never written so it stays zero.
  logic [31:0] mdl [32];

  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] d;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] qa;
    logic [31:0] qb;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  function automatic logic [31:0] mdl_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : mdl[a];
  endfunction

  // Expected port value before the edge, honouring the optional forwarding path.
  function automatic logic [31:0] exp_pre(input logic [4:0] a, input logic we,
                                          input logic [4:0] wr, input logic [31:0] d);
`ifdef REGFILE_BYPASS_EN
    if (we && wr != 5'd0 && a == wr) return d;
`endif
    return mdl_rd(a);
  endfunction

  // Apply a write at one edge and leave sampling point at edge+1.
  task automatic do_write(input logic [4:0] wr, input logic [31:0] d);
    rf.We = 1'b1; rf.Wr = wr; rf.D = d;
    @(posedge Clk); #1;
    if (wr != 5'd0) mdl[wr] = d;
    rf.We = 1'b0;
  endtask

  initial begin
    rf.Ra = '0; rf.Rb = '0; rf.Wr = '0; rf.We = 1'b0; rf.D = '0;
    Clrn = 1'b0;
    mdl_clear();

    // Reset sweep: every address reads zero on both ports, even with a write pending.
    rf.We = 1'b1; rf.Wr = 5'd4; rf.D = 32'hFFFF_FFFF;
    #2;
    for (int a = 0; a < 32; a++) begin
      rf.Ra = 5'(a); rf.Rb = 5'(31 - a);
      #1;
      chk("reset_qa", rf.Qa, 32'h0);
      chk("reset_qb", rf.Qb, 32'h0);
    end
    rf.We = 1'b0;
    @(negedge Clk); Clrn = 1'b1;
    @(posedge Clk); #1;

    // Directed table: inputs held across one edge, checked just after it.
    vecs[0] = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[1] = '{1'b0, 5'd5,  32'h1234_5678, 5'd5,  5'd5,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd5,  32'h0,         32'hDEAD_BEEF};
    vecs[3] = '{1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd5,  32'h1,         32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 5'd31, 32'h8000_0000, 5'd1,  5'd31, 32'h1,         32'h8000_0000};
    vecs[5] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd1,  32'h8000_0000, 32'h1};
    vecs[6] = '{1'b0, 5'd0,  32'h0,         5'd31, 5'd31, 32'h8000_0000, 32'h8000_0000};
    vecs[7] = '{1'b1, 5'd7,  32'h0000_0011, 5'd7,  5'd0,  32'h11,        32'h0};
    vecs[8] = '{1'b1, 5'd9,  32'h0000_000A, 5'd9,  5'd7,  32'hA,         32'h11};
    vecs[9] = '{1'b1, 5'd9,  32'h0000_000B, 5'd9,  5'd7,  32'hB,         32'h11};
    for (int i = 0; i < 10; i++) begin
      rf.We = vecs[i].we; rf.Wr = vecs[i].wr; rf.D = vecs[i].d;
      rf.Ra = vecs[i].ra; rf.Rb = vecs[i].rb;
      @(posedge Clk); #1;
      if (vecs[i].we && vecs[i].wr != 5'd0) mdl[vecs[i].wr] = vecs[i].d;
      chk($sformatf("vec%0d_qa", i), rf.Qa, vecs[i].qa);
      chk($sformatf("vec%0d_qb", i), rf.Qb, vecs[i].qb);
    end
    rf.We = 1'b0;

    // Write to r0 must leave r0 zero and disturb nothing else.
    do_write(5'd0, 32'hFFFF_FFFF);
    rf.Ra = 5'd0; #1;
    chk("r0_read", rf.Qa, 32'h0);
    for (int a = 1; a < 32; a++) begin
      rf.Ra = 5'(a); #1;
      chk($sformatf("r0_side_r%0d", a), rf.Qa, mdl[a]);
    end

    // Same-cycle read/write of r7 (holds 0x11).
    rf.We = 1'b1; rf.Wr = 5'd7; rf.D = 32'h22; rf.Ra = 5'd7; rf.Rb = 5'd0;
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("same_cycle_pre", rf.Qa, 32'h22);
`else
    chk("same_cycle_pre", rf.Qa, 32'h11);
`endif
    @(posedge Clk); #1;
    mdl[7] = 32'h22;
    chk("same_cycle_post", rf.Qa, 32'h22);
    rf.We = 1'b0; #1;
    chk("same_cycle_hold", rf.Qa, 32'h22);

    // Async reset mid-operation.
    for (int a = 1; a < 32; a++) do_write(5'(a), 32'(a));
    rf.Ra = 5'd3; rf.Rb = 5'd30; #1;
    chk("fill_r3", rf.Qa, 32'd3);
    chk("fill_r30", rf.Qb, 32'd30);
    rf.We = 1'b1; rf.Wr = 5'd3; rf.D = 32'hAAAA_AAAA;
    #1 Clrn = 1'b0;   // between edges
    mdl_clear();
    #0.5;
    chk("arst_immediate_qa", rf.Qa, 32'h0);
    chk("arst_immediate_qb", rf.Qb, 32'h0);
    for (int a = 0; a < 32; a++) begin
      rf.Ra = 5'(a); #0.25;
      chk("arst_sweep", rf.Qa, 32'h0);
    end
    @(posedge Clk); @(posedge Clk); #1;
    rf.Ra = 5'd3;
    chk("arst_held_r3", rf.Qa, 32'h0);
    @(negedge Clk);
    rf.We = 1'b0; Clrn = 1'b1; #1;
    chk("arst_release_r3", rf.Qa, 32'h0);
    do_write(5'd3, 32'hAAAA_AAAA);
    chk("arst_first_write", rf.Qa, 32'hAAAA_AAAA);
    rf.Ra = 5'd4; #1;
    chk("arst_r4_cleared", rf.Qa, 32'h0);

    // Randomized traffic against the model; addresses biased toward collisions.
    for (int n = 0; n < 400; n++) begin
      logic        we;
      logic [4:0]  wr, ra, rb;
      logic [31:0] d;
      we = 1'($urandom_range(0, 1));
      wr = 5'($urandom_range(0, 31));
      d  = $urandom;
      ra = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
      rb = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom_range(0, 31));
      rf.We = we; rf.Wr = wr; rf.D = d; rf.Ra = ra; rf.Rb = rb;
      #2;
      chk("rand_pre_qa", rf.Qa, exp_pre(ra, we, wr, d));
      chk("rand_pre_qb", rf.Qb, exp_pre(rb, we, wr, d));
      @(posedge Clk); #1;
      if (we && wr != 5'd0) mdl[wr] = d;
      rf.We = 1'b0; #1;
      chk("rand_post_qa", rf.Qa, mdl_rd(ra));
      chk("rand_post_qb", rf.Qb, mdl_rd(rb));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
